uart_7seg_mux: RTL and testbench

- UART-commanded, N-digit multiplexed 7-segment display controller for iCE40 Pmod boards.
- Receives ASCII frames "S<hex digits>\n" over 8N1 serial, validates them, and commits the digits atomically to a display buffer.
- Drives the segments and the one-hot digit selects with a time-multiplexed scan.
- Generalises the fixed 2-digit Pmod 7-segment design in digit count, clock, baud and scan rate, and adds error reporting.

---
 rtl/uart_7seg_pkg.sv | 36 +++
 rtl/uart_rx_8n1.sv | 85 ++++++++
 rtl/uart_7seg_mux.sv | 155 +++++++++++++++
 tb/tb_uart_7seg_mux.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_7seg_pkg.sv
// Shared constants, parser state encoding and character/glyph helpers for uart_7seg_mux.
package uart_7seg_pkg;

  localparam logic [7:0] ASC_S  = 8'h53;
  localparam logic [7:0] ASC_NL = 8'h0A;
  localparam logic [7:0] ASC_K  = 8'h4B;
  localparam logic [7:0] ASC_Q  = 8'h3F;

  typedef enum logic [1:0] {P_IDLE, P_COLLECT, P_WAIT_NL, P_ERR} pstate_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] val;
  } nib_t;

  function automatic logic [6:0] font(input logic [3:0] h);
    case (h)
      4'h0: font = 7'h3F;  4'h1: font = 7'h06;  4'h2: font = 7'h5B;  4'h3: font = 7'h4F;
      4'h4: font = 7'h66;  4'h5: font = 7'h6D;  4'h6: font = 7'h7D;  4'h7: font = 7'h07;
      4'h8: font = 7'h7F;  4'h9: font = 7'h6F;  4'hA: font = 7'h77;  4'hB: font = 7'h7C;
      4'hC: font = 7'h39;  4'hD: font = 7'h5E;  4'hE: font = 7'h79;  default: font = 7'h71;
    endcase
  endfunction

  // Letters A-F and a-f share their low nibble (1..6), so value = low nibble + 9.
  function automatic nib_t hex_dec(input logic [7:0] c);
    nib_t r;
    r.vld = 1'b1;
    r.val = c[3:0];
    if (c >= 8'h30 && c <= 8'h39)                                     r.val = c[3:0];
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) r.val = c[3:0] + 4'd9;
    else                                                              r.vld = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 serial receiver: 2-flop synchroniser, half-bit start confirm, mid-bit sampling.
module uart_rx_8n1 #(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = $clog2(CPB);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_t;

  rstate_t        st, st_n;
  logic [1:0]     sync;
  logic           rx_s, rx_prev;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2:0]     bitn, bit_n;
  logic [7:0]     sh, sh_n;
  logic           bv_n, fe_n;

  assign rx_s = sync[1];
  assign data = sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync       <= 2'b11;
      rx_prev    <= 1'b1;
      st         <= R_IDLE;
      cnt        <= '0;
      bitn       <= '0;
      sh         <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync       <= {sync[0], rx};
      rx_prev    <= rx_s;
      st         <= st_n;
      cnt        <= cnt_n;
      bitn       <= bit_n;
      sh         <= sh_n;
      byte_valid <= bv_n;
      frame_err  <= fe_n;
    end
  end

  always_comb begin
    st_n  = st;
    cnt_n = cnt + CW'(1);
    bit_n = bitn;
    sh_n  = sh;
    bv_n  = 1'b0;
    fe_n  = 1'b0;
    case (st)
      R_IDLE: begin
        cnt_n = '0;
        if (rx_prev && !rx_s) st_n = R_START;
      end
      // A start glitch shorter than half a bit drops back to idle.
      R_START: if (cnt == CW'(CPB/2 - 1)) begin
        cnt_n = '0;
        bit_n = '0;
        st_n  = rx_s ? R_IDLE : R_DATA;
      end
      R_DATA: if (cnt == CW'(CPB - 1)) begin
        cnt_n = '0;
        sh_n  = {rx_s, sh[7:1]};
        bit_n = bitn + 3'd1;
        if (bitn == 3'd7) st_n = R_STOP;
      end
      R_STOP: if (cnt == CW'(CPB - 1)) begin
        cnt_n = '0;
        st_n  = R_IDLE;
        bv_n  = rx_s;
        fe_n  = !rx_s;
      end
      default: st_n = R_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_7seg_mux.sv
// UART-commanded multiplexed 7-segment controller. Frames "S<hex>\n" commit atomically.
// Define UART_7SEG_ACK_EN to send 'K'/'?' acks on TX; otherwise TX is tied high.
module uart_7seg_mux
  import uart_7seg_pkg::*;
#(
  parameter int CLK_HZ  = 12000000,
  parameter int BAUD    = 115200,
  parameter int DIGITS  = 2,
  parameter int SCAN_HZ = 1000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX,
  output logic              TX,
  output logic [6:0]        SEG,
  output logic [DIGITS-1:0] DIG_SEL,
  output logic              CMD_OK,
  output logic              CMD_ERR
);
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int XW = $clog2(DIGITS + 1);

  logic [7:0] rx_data;
  logic       byte_valid, frame_err;

  uart_rx_8n1 #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk(CLK), .rst(RST), .rx(RX),
    .data(rx_data), .byte_valid(byte_valid), .frame_err(frame_err)
  );

  pstate_t                 st, st_n;
  logic [XW-1:0]           idx, idx_n;
  logic [DIGITS-1:0][3:0]  shad, shad_n, disp, disp_n;
  logic                    ok_n, err_n;
  nib_t                    nib;

  always_ff @(posedge CLK) begin
    if (RST) begin
      st      <= P_IDLE;
      idx     <= '0;
      shad    <= '0;
      disp    <= '0;
      CMD_OK  <= 1'b0;
      CMD_ERR <= 1'b0;
    end else begin
      st      <= st_n;
      idx     <= idx_n;
      shad    <= shad_n;
      disp    <= disp_n;
      CMD_OK  <= ok_n;
      CMD_ERR <= err_n;
    end
  end

  always_comb begin
    st_n   = st;
    idx_n  = idx;
    shad_n = shad;
    disp_n = disp;
    ok_n   = 1'b0;
    err_n  = 1'b0;
    nib    = hex_dec(rx_data);
    if (frame_err) st_n = P_ERR;
    else if (byte_valid) begin
      case (st)
        P_IDLE:
          if (rx_data == ASC_S) begin
            st_n  = P_COLLECT;
            idx_n = '0;
          end else if (rx_data != ASC_NL) st_n = P_ERR;
        // First character received goes to the leftmost (highest) digit.
        P_COLLECT:
          if (nib.vld) begin
            for (int i = 0; i < DIGITS; i++)
              if (i == DIGITS - 1 - int'(idx)) shad_n[i] = nib.val;
            idx_n = idx + XW'(1);
            if (int'(idx) == DIGITS - 1) st_n = P_WAIT_NL;
          end else if (rx_data == ASC_NL) begin
            err_n = 1'b1;
            st_n  = P_IDLE;
          end else st_n = P_ERR;
        P_WAIT_NL:
          if (rx_data == ASC_NL) begin
            disp_n = shad;
            ok_n   = 1'b1;
            st_n   = P_IDLE;
          end else st_n = P_ERR;
        default:
          if (rx_data == ASC_NL) begin
            err_n = 1'b1;
            st_n  = P_IDLE;
          end
      endcase
    end
  end

  logic [SW-1:0] pre;
  logic [IW-1:0] sidx, sidx_n;
  logic          last;

  assign last   = (pre == SW'(SCAN_DIV - 1));
  assign sidx_n = !last ? sidx : (sidx == IW'(DIGITS - 1)) ? '0 : sidx + IW'(1);

  // Segments follow next-cycle buffer/index so a commit coinciding with a step shows at once.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pre     <= '0;
      sidx    <= '0;
      DIG_SEL <= DIGITS'(1);
      SEG     <= 7'h3F;
    end else begin
      pre     <= last ? '0 : pre + SW'(1);
      sidx    <= sidx_n;
      DIG_SEL <= DIGITS'(1) << sidx_n;
      SEG     <= font(disp_n[sidx_n]);
    end
  end

`ifdef UART_7SEG_ACK_EN
  localparam int CPB = CLK_HZ / BAUD;
  localparam int TW  = $clog2(CPB);

  logic [9:0]    tsh;
  logic [3:0]    tbits;
  logic [TW-1:0] tcnt;

  // Requests arriving while a byte is in flight are dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tsh   <= '1;
      tbits <= '0;
      tcnt  <= '0;
    end else if (tbits == 4'd0) begin
      if (CMD_OK || CMD_ERR) begin
        tsh   <= {1'b1, (CMD_OK ? ASC_K : ASC_Q), 1'b0};
        tbits <= 4'd10;
        tcnt  <= '0;
      end
    end else if (tcnt == TW'(CPB - 1)) begin
      tcnt  <= '0;
      tsh   <= {1'b1, tsh[9:1]};
      tbits <= tbits - 4'd1;
    end else begin
      tcnt  <= tcnt + TW'(1);
    end
  end

  assign TX = (tbits == 4'd0) ? 1'b1 : tsh[0];
`else
  assign TX = 1'b1;
`endif

endmodule

// File: tb/tb_uart_7seg_mux.sv
// Bench for uart_7seg_mux: frame table with pulse scoreboard, plus framing/reset/scan corner cases.
`timescale 1ns/1ps
module tb_uart_7seg_mux;
  localparam int CPB = 104;

  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, rx4 = 1'b1;
  logic tx, ok, err, tx4, ok4, err4;
  logic [6:0] seg, seg4;
  logic [1:0] dsel;
  logic [3:0] sel4;

  always #41.667 clk = ~clk;

  uart_7seg_mux #(.CLK_HZ(12000000), .BAUD(115200), .DIGITS(2), .SCAN_HZ(200000)) dut (
    .CLK(clk), .RST(rst), .RX(rx), .TX(tx), .SEG(seg), .DIG_SEL(dsel), .CMD_OK(ok), .CMD_ERR(err)
  );

  uart_7seg_mux #(.CLK_HZ(12000000), .BAUD(115200), .DIGITS(4), .SCAN_HZ(1200000)) dut4 (
    .CLK(clk), .RST(rst), .RX(rx4), .TX(tx4), .SEG(seg4), .DIG_SEL(sel4), .CMD_OK(ok4), .CMD_ERR(err4)
  );

  int total = 0, bad = 0, tx_low = 0, ev4 = 0;
  byte exp_q[$];
  byte ack_q[$];

  typedef struct {
    string      frame;
    byte        kind;
    logic [6:0] l;
    logic [6:0] r;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard: each CMD_OK/CMD_ERR pulse must match the next expected event.
  always @(negedge clk) begin
    if (!rst && (ok || err)) begin
      if (ok && err) chk("pulse_both", 1, 0);
      if (exp_q.size() == 0) chk("pulse_unexpected", ok ? 32'h4B : 32'h3F, 0);
      else chk("pulse_kind", ok ? 32'h4B : 32'h3F, 32'(exp_q.pop_front()));
    end
    if (tx !== 1'b1) tx_low++;
    if (!rst && (ok4 || err4 || tx4 !== 1'b1)) ev4++;
  end

`ifdef UART_7SEG_ACK_EN
  initial forever begin
    logic [7:0] b;
    @(negedge tx);
    repeat (CPB/2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx;
    end
    if (ack_q.size() == 0) chk("ack_unexpected", b, 0);
    else chk("ack_byte", b, 32'(ack_q.pop_front()));
  end
`endif

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!stop) repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic check_digit(input string name, input logic [1:0] sel, input logic [6:0] exp);
    int n = 0;
    @(negedge clk);
    while (dsel !== sel && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk({name, "_timeout"}, 0, 1);
    else chk(name, seg, exp);
  endtask

  task automatic run_len(input logic [3:0] v, output int n);
    n = 0;
    while (sel4 === v && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic expect_ev(input byte k);
    exp_q.push_back(k);
    ack_q.push_back(k);
  endtask

  initial begin
    int n;
    vecs[0] = '{"SE6\n",  8'h4B, 7'h79, 7'h7D};
    vecs[1] = '{"Sa5\n",  8'h4B, 7'h77, 7'h6D};
    vecs[2] = '{"S0E6\n", 8'h3F, 7'h77, 7'h6D};
    vecs[3] = '{"S3\n",   8'h3F, 7'h77, 7'h6D};
    vecs[4] = '{"X12\n",  8'h3F, 7'h77, 7'h6D};
    vecs[5] = '{"\n",     8'h00, 7'h77, 7'h6D};
    vecs[6] = '{"SfF\n",  8'h4B, 7'h71, 7'h71};
    vecs[7] = '{"S9c\n",  8'h4B, 7'h6F, 7'h39};

    repeat (4) @(negedge clk);
    chk("rst_seg", seg, 7'h3F);
    chk("rst_dsel", dsel, 2'b01);
    chk("rst_tx", tx, 1'b1);
    chk("rst_ok", ok, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_sel4", sel4, 4'b0001);
    rst = 1'b0;

    // 4-digit scan: each select held exactly SCAN_DIV = 10 cycles, rotating left.
    n = 0;
    while (sel4 !== 4'b0010 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("scan_reach_0010", sel4, 4'b0010);
    run_len(4'b0010, n);  chk("scan_len_0010", n, 10);
    chk("scan_0100", sel4, 4'b0100);
    run_len(4'b0100, n);  chk("scan_len_0100", n, 10);
    chk("scan_1000", sel4, 4'b1000);
    run_len(4'b1000, n);  chk("scan_len_1000", n, 10);
    chk("scan_wrap_0001", sel4, 4'b0001);

    for (int k = 0; k < 8; k++) begin
      if (vecs[k].kind != 8'h00) expect_ev(vecs[k].kind);
      send_frame(vecs[k].frame);
      repeat (4) @(negedge clk);
      check_digit($sformatf("v%0d_left", k), 2'b10, vecs[k].l);
      check_digit($sformatf("v%0d_right", k), 2'b01, vecs[k].r);
    end

    // Framing error on 'S', then newline: one CMD_ERR, no commit.
    expect_ev(8'h3F);
    send_byte(8'h53, 1'b0);
    send_byte(8'h0A, 1'b1);
    repeat (4) @(negedge clk);
    check_digit("ferr_left", 2'b10, 7'h6F);
    check_digit("ferr_right", 2'b01, 7'h39);
    expect_ev(8'h4B);
    send_frame("S08\n");
    repeat (4) @(negedge clk);
    check_digit("s08_left", 2'b10, 7'h3F);
    check_digit("s08_right", 2'b01, 7'h7F);

    // Reset in the middle of '5' of "S45\n".
    send_byte(8'h53, 1'b1);
    send_byte(8'h34, 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    rx = 1'b0;
    repeat (CPB/2) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("midrst_dsel", dsel, 2'b01);
    check_digit("midrst_left", 2'b10, 7'h3F);
    check_digit("midrst_right", 2'b01, 7'h3F);
    expect_ev(8'h4B);
    send_frame("S45\n");
    repeat (4) @(negedge clk);
    check_digit("s45_left", 2'b10, 7'h66);
    check_digit("s45_right", 2'b01, 7'h6D);

    repeat (1300) @(negedge clk);
    chk("pending_pulses", exp_q.size(), 0);
`ifdef UART_7SEG_ACK_EN
    chk("pending_acks", ack_q.size(), 0);
`else
    chk("tx_idle", tx_low, 0);
`endif
    chk("dig4_quiet", ev4, 0);
    chk("dig4_seg", seg4, 7'h3F);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
